// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit unsigned adder with carry-in, split into
// NUM_SEG = WIDTH/SEG_W registered carry segments. Valid/ready flow control
// on both sides with bubble collapsing; one addition per clock at full rate.
// Optional feature macro: PIPELINED_ADDER_OVF_EN adds a registered OVF output
// (two's-complement signed overflow) aligned with SUM.

// One carry segment: adds operand segment K plus the incoming carry and
// forwards the still-unadded operand bits to the next stage.
module pipelined_adder_seg #(
   parameter int WIDTH = 16,
   parameter int SEG_W = 4,
   parameter int K     = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_sum,
   input  logic             in_c,
   output logic             vld,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             c
);
   logic [SEG_W:0]   seg_add;
   logic [WIDTH-1:0] sum_nxt;

   // segment add in SEG_W+1 bits; MSB is the carry into the next segment
   always_comb begin
      seg_add = {1'b0, in_a[K*SEG_W +: SEG_W]} + {1'b0, in_b[K*SEG_W +: SEG_W]}
              + {{SEG_W{1'b0}}, in_c};
      sum_nxt = in_sum;
      sum_nxt[K*SEG_W +: SEG_W] = seg_add[SEG_W-1:0];
   end

   // stage register: valid follows the load; payload only captured for valid
   // data so garbage on an idle input never lands in the datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= 1'b0;
         a   <= '0;
         b   <= '0;
         sum <= '0;
         c   <= 1'b0;
      end else if (ld) begin
         vld <= in_vld;
         if (in_vld) begin
            a   <= in_a;
            b   <= in_b;
            sum <= sum_nxt;
            c   <= seg_add[SEG_W];
         end
      end
   end
endmodule

module pipelined_adder #(
   parameter int WIDTH = 16,
   parameter int SEG_W = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   input  logic             CARRY_in,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic [WIDTH-1:0] SUM,
   output logic             CARRY,
   output logic             OUT_VALID,
`ifdef PIPELINED_ADDER_OVF_EN
   output logic             OVF,
`endif
   input  logic             OUT_READY
);
   localparam int NUM_SEG = (SEG_W > 0) ? WIDTH / SEG_W : 1;

   if ((WIDTH < 1) || (SEG_W < 1) || (WIDTH % SEG_W != 0)) begin : g_bad_params
      $error("pipelined_adder: SEG_W must be >= 1 and divide WIDTH exactly");
   end

   // index 0 is the input port side, index k+1 is the output of stage k
   logic [NUM_SEG:0][WIDTH-1:0] a_p, b_p, s_p;
   logic [NUM_SEG:0]            c_p;
   logic [NUM_SEG:0]            vld_pipe;
   logic [NUM_SEG-1:0]          ld;

   assign a_p[0]      = A_in;
   assign b_p[0]      = B_in;
   assign s_p[0]      = '0;
   assign c_p[0]      = CARRY_in;
   assign vld_pipe[0] = IN_VALID;

   for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
      // stage k may load if any stage from k up to the output is empty or the
      // output is being drained; flattened so there is no chain through ld
      localparam logic [NUM_SEG-1:0] LOW = ~({NUM_SEG{1'b1}} << k);
      assign ld[k] = OUT_READY | ~&(vld_pipe[NUM_SEG:1] | LOW);

      pipelined_adder_seg #(.WIDTH(WIDTH), .SEG_W(SEG_W), .K(k)) u_seg (
         .clk    (CLK),
         .rst    (RST),
         .ld     (ld[k]),
         .in_vld (vld_pipe[k]),
         .in_a   (a_p[k]),
         .in_b   (b_p[k]),
         .in_sum (s_p[k]),
         .in_c   (c_p[k]),
         .vld    (vld_pipe[k+1]),
         .a      (a_p[k+1]),
         .b      (b_p[k+1]),
         .sum    (s_p[k+1]),
         .c      (c_p[k+1])
      );
   end

   assign IN_READY  = ld[0];
   assign SUM       = s_p[NUM_SEG];
   assign CARRY     = c_p[NUM_SEG];
   assign OUT_VALID = vld_pipe[NUM_SEG];

   // the last stage's forwarded operand copy has no consumer
   logic unused_ops;
   assign unused_ops = ^{a_p[NUM_SEG], b_p[NUM_SEG]};

`ifdef PIPELINED_ADDER_OVF_EN
   logic [SEG_W:0] last_add;
   logic           ovf_q;

   // redo the top segment's add to recover the carry into bit WIDTH-1
   always_comb begin
      last_add = {1'b0, a_p[NUM_SEG-1][WIDTH-1 -: SEG_W]}
               + {1'b0, b_p[NUM_SEG-1][WIDTH-1 -: SEG_W]}
               + {{SEG_W{1'b0}}, c_p[NUM_SEG-1]};
   end

   // overflow flag shares the last stage's load/hold timing
   always_ff @(posedge CLK) begin
      if (RST)
         ovf_q <= 1'b0;
      else if (ld[NUM_SEG-1] && vld_pipe[NUM_SEG-1])
         ovf_q <= (a_p[NUM_SEG-1][WIDTH-1] ^ b_p[NUM_SEG-1][WIDTH-1] ^ last_add[SEG_W-1])
                ^ last_add[SEG_W];
   end

   assign OVF = ovf_q;
`else
   // no overflow tracking in this build
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (defaults WIDTH=16, SEG_W=4).
module tb_pipelined_adder;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] A_in = '0, B_in = '0;
   logic        CARRY_in = 1'b0, IN_VALID = 1'b0, OUT_READY = 1'b1;
   logic        IN_READY, CARRY, OUT_VALID;
   logic [15:0] SUM;
`ifdef PIPELINED_ADDER_OVF_EN
   logic        OVF;
`endif

   int checks = 0;
   int failures = 0;

   pipelined_adder #(.WIDTH(16), .SEG_W(4)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .A_in      (A_in),
      .B_in      (B_in),
      .CARRY_in  (CARRY_in),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .SUM       (SUM),
      .CARRY     (CARRY),
      .OUT_VALID (OUT_VALID),
`ifdef PIPELINED_ADDER_OVF_EN
      .OVF       (OVF),
`endif
      .OUT_READY (OUT_READY)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc;
      @(posedge CLK);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic test_reset;
      RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
      repeat (3) cyc();
      checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", OUT_VALID); end
      checks++; if (SUM !== 16'h0000) begin failures++; $display("FAIL reset_sum: got %h want 0000", SUM); end
      checks++; if (CARRY !== 1'b0) begin failures++; $display("FAIL reset_carry: got %b want 0", CARRY); end
`ifdef PIPELINED_ADDER_OVF_EN
      checks++; if (OVF !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", OVF); end
`endif
      RST = 1'b0;
      cyc();
      checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", IN_READY); end
   endtask

   task automatic test_single;
      A_in = 16'h1234; B_in = 16'h4321; CARRY_in = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b1;
      cyc();
      IN_VALID = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         if (i > 1) cyc();
         checks++;
         if (OUT_VALID !== (i == 4)) begin
            failures++; $display("FAIL single_latency: cycle %0d got %b want %b", i, OUT_VALID, (i == 4));
         end
      end
      checks++; if (SUM !== 16'h5555) begin failures++; $display("FAIL single_sum: got %h want 5555", SUM); end
      checks++; if (CARRY !== 1'b0) begin failures++; $display("FAIL single_carry: got %b want 0", CARRY); end
      cyc();
      checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL single_drain: got %b want 0", OUT_VALID); end
   endtask

   task automatic test_carry_ripple;
      logic [15:0] va [3] = '{16'hFFFF, 16'h7FFF, 16'hFFFF};
      logic [15:0] vb [3] = '{16'h0001, 16'h0000, 16'hFFFF};
      logic        vc [3] = '{1'b0, 1'b1, 1'b1};
      logic [15:0] es [3] = '{16'h0000, 16'h8000, 16'hFFFF};
      logic        ec [3] = '{1'b1, 1'b0, 1'b1};
      logic        eo [3] = '{1'b0, 1'b1, 1'b0};
      OUT_READY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         A_in = va[i]; B_in = vb[i]; CARRY_in = vc[i]; IN_VALID = 1'b1;
         cyc();
      end
      IN_VALID = 1'b0;
      cyc();
      for (int j = 0; j < 3; j++) begin
         if (j > 0) cyc();
         checks++; if (OUT_VALID !== 1'b1) begin failures++; $display("FAIL ripple_valid[%0d]: got %b want 1", j, OUT_VALID); end
         checks++; if (SUM !== es[j]) begin failures++; $display("FAIL ripple_sum[%0d]: got %h want %h", j, SUM, es[j]); end
         checks++; if (CARRY !== ec[j]) begin failures++; $display("FAIL ripple_carry[%0d]: got %b want %b", j, CARRY, ec[j]); end
`ifdef PIPELINED_ADDER_OVF_EN
         checks++; if (OVF !== eo[j]) begin failures++; $display("FAIL ripple_ovf[%0d]: got %b want %b", j, OVF, eo[j]); end
`else
         if (eo[j] === 1'bx) $display("unexpected x in overflow table");
`endif
      end
      cyc();
      checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL ripple_drain: got %b want 0", OUT_VALID); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] va [20], vb [20];
      logic        vc [20];
      logic [16:0] ex [20];
      for (int i = 0; i < 20; i++) begin
         va[i] = 16'($urandom); vb[i] = 16'($urandom); vc[i] = 1'($urandom);
         ex[i] = {1'b0, va[i]} + {1'b0, vb[i]} + {16'b0, vc[i]};
      end
      OUT_READY = 1'b1;
      for (int t = 0; t < 24; t++) begin
         if (t < 20) begin
            A_in = va[t]; B_in = vb[t]; CARRY_in = vc[t]; IN_VALID = 1'b1;
         end else IN_VALID = 1'b0;
         settle();
         if (t < 20) begin
            checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", t, IN_READY); end
         end
         cyc();
         if (t >= 3 && t < 23) begin
            checks++;
            if (OUT_VALID !== 1'b1 || {CARRY, SUM} !== ex[t-3]) begin
               failures++; $display("FAIL b2b_result[%0d]: got v=%b %h want v=1 %h", t-3, OUT_VALID, {CARRY, SUM}, ex[t-3]);
            end
         end else begin
            checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL b2b_idle[%0d]: got %b want 0", t, OUT_VALID); end
         end
      end
   endtask

   task automatic test_backpressure;
      logic [16:0] q [$];
      logic [16:0] hold;
      int accepts = 0;
      OUT_READY = 1'b0; IN_VALID = 1'b1;
      for (int c = 0; c < 8; c++) begin
         A_in = 16'($urandom); B_in = 16'($urandom); CARRY_in = 1'($urandom);
         settle();
         if (IN_READY === 1'b1) begin
            q.push_back({1'b0, A_in} + {1'b0, B_in} + {16'b0, CARRY_in});
            accepts++;
         end
         cyc();
         if (c == 4) hold = {CARRY, SUM};
      end
      settle();
      checks++; if (accepts != 4) begin failures++; $display("FAIL bp_accepts: got %0d want 4", accepts); end
      checks++; if (IN_READY !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full: got %b want 0", IN_READY); end
      checks++; if (OUT_VALID !== 1'b1) begin failures++; $display("FAIL bp_out_valid: got %b want 1", OUT_VALID); end
      checks++; if ({CARRY, SUM} !== hold) begin failures++; $display("FAIL bp_stable: got %h want %h", {CARRY, SUM}, hold); end
      IN_VALID = 1'b0; OUT_READY = 1'b1;
      settle();
      checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b want 1", IN_READY); end
      for (int j = 0; j < 4; j++) begin
         checks++;
         if (OUT_VALID !== 1'b1 || q.size() <= j || {CARRY, SUM} !== q[j]) begin
            failures++; $display("FAIL bp_result[%0d]: got v=%b %h want v=1 %h", j, OUT_VALID, {CARRY, SUM}, (q.size() > j) ? q[j] : 17'h0);
         end
         cyc();
      end
      checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL bp_drain: got %b want 0", OUT_VALID); end
   endtask

   task automatic test_random_stalls;
      logic [16:0] q [$];
      logic [16:0] hold = '0;
      logic [16:0] e;
      logic        stall_prev = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         IN_VALID = 1'($urandom); OUT_READY = 1'($urandom);
         A_in = 16'($urandom); B_in = 16'($urandom); CARRY_in = 1'($urandom);
         settle();
         if (stall_prev) begin
            checks++;
            if (OUT_VALID !== 1'b1 || {CARRY, SUM} !== hold) begin
               failures++; $display("FAIL rnd_stall_hold[%0d]: got v=%b %h want v=1 %h", n, OUT_VALID, {CARRY, SUM}, hold);
            end
         end
         if (IN_VALID && IN_READY) q.push_back({1'b0, A_in} + {1'b0, B_in} + {16'b0, CARRY_in});
         if (OUT_VALID && OUT_READY) begin
            e = (q.size() > 0) ? q.pop_front() : 17'h0;
            checks++;
            if ({CARRY, SUM} !== e) begin failures++; $display("FAIL rnd_result[%0d]: got %h want %h", n, {CARRY, SUM}, e); end
         end
         stall_prev = OUT_VALID && !OUT_READY;
         hold = {CARRY, SUM};
         cyc();
      end
      IN_VALID = 1'b0; OUT_READY = 1'b1;
      for (int n = 0; n < 16; n++) begin
         settle();
         if (OUT_VALID === 1'b1) begin
            e = (q.size() > 0) ? q.pop_front() : 17'h0;
            checks++;
            if ({CARRY, SUM} !== e) begin failures++; $display("FAIL rnd_drain_result: got %h want %h", {CARRY, SUM}, e); end
         end
         cyc();
      end
      checks++; if (q.size() != 0) begin failures++; $display("FAIL rnd_lost: got %0d pending want 0", q.size()); end
      checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL rnd_empty: got %b want 0", OUT_VALID); end
   endtask

   task automatic test_reset_midstream;
      OUT_READY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         A_in = 16'h0101 * 16'(i + 1); B_in = 16'h0202; CARRY_in = 1'b1; IN_VALID = 1'b1;
         cyc();
      end
      RST = 1'b1; A_in = 16'h00AA; B_in = 16'h0055;
      cyc();
      RST = 1'b0; IN_VALID = 1'b0;
      checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b want 0", OUT_VALID); end
      checks++; if (SUM !== 16'h0000 || CARRY !== 1'b0) begin failures++; $display("FAIL mid_rst_outputs: got %h want 00000", {CARRY, SUM}); end
      for (int i = 0; i < 6; i++) begin
         cyc();
         checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL mid_rst_discard[%0d]: got %b want 0", i, OUT_VALID); end
      end
      A_in = 16'h0002; B_in = 16'h0003; CARRY_in = 1'b0; IN_VALID = 1'b1;
      cyc();
      IN_VALID = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         if (i > 1) cyc();
         checks++;
         if (OUT_VALID !== (i == 4)) begin failures++; $display("FAIL mid_rst_latency: cycle %0d got %b want %b", i, OUT_VALID, (i == 4)); end
      end
      checks++; if (SUM !== 16'h0005 || CARRY !== 1'b0) begin failures++; $display("FAIL mid_rst_sum: got %h want 00005", {CARRY, SUM}); end
      cyc();
   endtask

   initial begin
      test_reset();
      test_single();
      test_carry_ripple();
      test_back_to_back();
      test_backpressure();
      test_random_stalls();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
